// File: rtl/add_share_sched.sv
// Shared signed adder for four requesters: round-robin arbitration, one operation in flight,
// result held until the consumer acknowledges it.
module add_share_sched #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [3:0]             req,
  input  logic [4*DATAWIDTH-1:0] a_bus,
  input  logic [4*DATAWIDTH-1:0] b_bus,
  input  logic                   ack,
  output logic [3:0]             gnt,
  output logic [DATAWIDTH-1:0]   sum,
  output logic                   ovf,
  output logic [1:0]             id,
  output logic                   valid
);

  localparam int unsigned Msb = DATAWIDTH - 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e               state_q;
  logic [3:0]           gnt_q;
  logic [DATAWIDTH-1:0] sum_q;
  logic                 ovf_q;
  logic [1:0]           id_q;
  logic                 valid_q;
  logic [1:0]           last_q;
  logic [DATAWIDTH-1:0] op_a_q;
  logic [DATAWIDTH-1:0] op_b_q;

  // Round-robin search starting one past the last winner, wrapping modulo 4.
  logic [1:0] win_idx;
  logic       win_found;
  logic [1:0] cand;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic [DATAWIDTH-1:0] win_a;
  logic [DATAWIDTH-1:0] win_b;

  assign win_a = a_bus[int'(win_idx)*DATAWIDTH +: DATAWIDTH];
  assign win_b = b_bus[int'(win_idx)*DATAWIDTH +: DATAWIDTH];

  logic [DATAWIDTH-1:0] add_res;
  logic                 add_ovf;

  assign add_res = op_a_q + op_b_q;
  // Overflow: operands agree in sign but the wrapped result does not.
  assign add_ovf = (op_a_q[Msb] == op_b_q[Msb]) && (add_res[Msb] != op_a_q[Msb]);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          gnt_q <= '0;
          if (win_found) begin
            op_a_q  <= win_a;
            op_b_q  <= win_b;
            gnt_q   <= 4'b0001 << win_idx;
            last_q  <= win_idx;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          gnt_q   <= '0;
          sum_q   <= add_res;
          ovf_q   <= add_ovf;
          id_q    <= last_q;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          gnt_q   <= '0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign sum   = sum_q;
  assign ovf   = ovf_q;
  assign id    = id_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_add_share_sched.sv
// Scoreboard bench for add_share_sched: stimulus predicts winner and result from an arithmetic
// model and queues it; a monitor pops and compares each time valid rises.
module tb_add_share_sched;

  localparam int W = 8;

  logic             Clk;
  logic             Rst;
  logic [3:0]       req;
  logic [4*W-1:0]   a_bus;
  logic [4*W-1:0]   b_bus;
  logic             ack;
  logic [3:0]       gnt;
  logic [W-1:0]     sum;
  logic             ovf;
  logic [1:0]       id;
  logic             valid;

  add_share_sched #(.DATAWIDTH(W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .req   (req),
    .a_bus (a_bus),
    .b_bus (b_bus),
    .ack   (ack),
    .gnt   (gnt),
    .sum   (sum),
    .ovf   (ovf),
    .id    (id),
    .valid (valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
    logic [1:0]   id;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic exp_t expect_of(input int w, input logic [4*W-1:0] ab,
                                     input logic [4*W-1:0] bb);
    exp_t e;
    int   ai;
    int   bi;
    int   s;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = ab[w*W +: W];
    bv = bb[w*W +: W];
    ai = int'($signed(av));
    bi = int'($signed(bv));
    s  = ai + bi;
    e.sum = W'(s);
    e.ovf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    e.id  = 2'(w);
    return e;
  endfunction

  function automatic logic [4*W-1:0] rand_bus();
    logic [4*W-1:0] v;
    for (int i = 0; i < 4; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic logic [4*W-1:0] put_op(input logic [4*W-1:0] base, input int w,
                                            input int val);
    logic [4*W-1:0] v;
    v = base;
    v[w*W +: W] = W'(val);
    return v;
  endfunction

  // One full operation from IDLE; returns just after the ack edge.
  task automatic do_op(input logic [3:0] r, input logic [4*W-1:0] ab,
                       input logic [4*W-1:0] bb, input int ack_dly);
    int w;
    int n;
    req   = r;
    a_bus = ab;
    b_bus = bb;
    ack   = 1'b0;
    w     = rr_pick(model_last, r);
    n     = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (gnt == 4'b0000 && n < 4);
    chk("gnt_latency", 64'(n), 64'd1);
    chk("gnt_winner", 64'(gnt), 64'(4'b0001 << w));
    if (gnt != 4'b0000) begin
      sb_q.push_back(expect_of(w, ab, bb));
      model_last = w;
    end
    req   = 4'b0000;
    a_bus = rand_bus();
    b_bus = rand_bus();
    @(negedge Clk);
    chk("valid_rise", 64'(valid), 64'd1);
    repeat (ack_dly) @(negedge Clk);
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;
    chk("valid_clear", 64'(valid), 64'd0);
  endtask

  // Monitor: result check on valid rise, stability while held, gnt isolation.
  initial begin
    logic         pv;
    logic [3:0]   pg;
    logic [W-1:0] ps;
    logic         po;
    logic [1:0]   pid;
    exp_t         e;
    logic [3:0]   oh;
    pv = 1'b0; pg = '0; ps = '0; po = 1'b0; pid = '0;
    forever begin
      @(negedge Clk);
      if (valid && !pv) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1 expected no result at %0t", $time);
        end else begin
          e  = sb_q.pop_front();
          oh = 4'b0001 << e.id;
          chk("sum", 64'(sum), 64'(e.sum));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          chk("id", 64'(id), 64'(e.id));
          chk("gnt_before_valid", 64'(pg), 64'(oh));
        end
      end else if (valid && pv) begin
        chk("hold_stable", 64'({sum, ovf, id}), 64'({ps, po, pid}));
      end
      if (gnt != 4'b0000) chk("gnt_isolated", 64'({valid, pg != 4'b0000}), 64'd0);
      pv = valid; pg = gnt; ps = sum; po = ovf; pid = id;
    end
  end

  initial begin
    int c;
    int last_c;
    int n_gnt;
    int w;
    Rst   = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    ack   = 1'b0;
    model_last = 3;
    repeat (2) @(negedge Clk);
    chk("rst_outputs", 64'({gnt, sum, ovf, id, valid}), 64'd0);
    Rst = 1'b1;
    @(negedge Clk);

    // Single request, then both overflow directions.
    do_op(4'b0001, put_op(rand_bus(), 0, 5), put_op(rand_bus(), 0, 3), 0);
    do_op(4'b0100, put_op(rand_bus(), 2, 100), put_op(rand_bus(), 2, 50), 1);
    do_op(4'b0100, put_op(rand_bus(), 2, -100), put_op(rand_bus(), 2, -50), 2);

    // All requesting with ack tied high: rotation with a grant every 3 cycles.
    req    = 4'b1111;
    ack    = 1'b1;
    a_bus  = rand_bus();
    b_bus  = rand_bus();
    last_c = -1;
    n_gnt  = 0;
    for (c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (gnt != 4'b0000) begin
        w = rr_pick(model_last, 4'b1111);
        chk("rr_gnt", 64'(gnt), 64'(4'b0001 << w));
        if (last_c >= 0) chk("rr_interval", 64'(c - last_c), 64'd3);
        sb_q.push_back(expect_of(w, a_bus, b_bus));
        model_last = w;
        last_c = c;
        n_gnt++;
      end
    end
    req = 4'b0000;
    chk("rr_count", 64'(n_gnt), 64'd14);
    repeat (4) @(negedge Clk);
    ack = 1'b0;

    // Backpressure with req held: no grant while DONE, grant on the edge after ack.
    req   = 4'b0001;
    a_bus = rand_bus();
    b_bus = rand_bus();
    @(negedge Clk);
    w = rr_pick(model_last, 4'b0001);
    chk("bp_gnt", 64'(gnt), 64'(4'b0001 << w));
    sb_q.push_back(expect_of(w, a_bus, b_bus));
    model_last = w;
    repeat (11) @(negedge Clk);
    chk("bp_valid_held", 64'({valid, gnt}), 64'({1'b1, 4'b0000}));
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;
    chk("bp_after_ack", 64'({valid, gnt}), 64'd0);
    @(negedge Clk);
    chk("bp_next_gnt", 64'(gnt), 64'(4'b0001 << w));
    sb_q.push_back(expect_of(w, a_bus, b_bus));
    req = 4'b0000;
    @(negedge Clk);
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;

    // Reset while in ADD: outputs clear at once, result discarded, priority back to 0.
    req   = 4'b0010;
    a_bus = rand_bus();
    b_bus = rand_bus();
    @(negedge Clk);
    chk("mid_gnt", 64'(gnt), 64'(4'b0001 << rr_pick(model_last, 4'b0010)));
    Rst = 1'b0;
    req = 4'b0000;
    #1;
    chk("mid_rst_outputs", 64'({gnt, sum, ovf, id, valid}), 64'd0);
    model_last = 3;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    do_op(4'b1001, rand_bus(), rand_bus(), 0);
    do_op(4'b1000, rand_bus(), rand_bus(), 1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(1, 15)), rand_bus(), rand_bus(), $urandom_range(0, 3));
    end

    repeat (5) @(negedge Clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_share_sched.md
ADD_SHARE_SCHED -- requirements
Module: add_share_sched

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: one request line per requester, index 0..3.
REQ-005 The block SHALL have port a_bus, input, 4*DATAWIDTH bits: signed operand A of requester i, at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-006 The block SHALL have port b_bus, input, 4*DATAWIDTH bits: signed operand B of requester i, packed the same way as a_bus.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer accepts the presented result.
REQ-008 The block SHALL have port gnt, output, 4 bits: one-hot grant pulse marking operand capture.
REQ-009 The block SHALL have port sum, output, DATAWIDTH bits: signed result register.
REQ-010 The block SHALL have port ovf, output, 1 bit: signed overflow of the presented result.
REQ-011 The block SHALL have port id, output, 2 bits: index of the requester that owns the presented result.
REQ-012 The block SHALL have port valid, output, 1 bit: sum, ovf and id are valid.

Function
REQ-013 The block SHALL time-share one signed DATAWIDTH adder and one result register among the four requesters.
REQ-014 The block SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-015 All outputs SHALL be registered.
REQ-016 In IDLE, on a rising edge with req != 0, the block SHALL select a winner by round-robin, starting at (last+1) mod 4 and ascending with wrap.
REQ-017 On that same edge the block SHALL latch the winner's A and B into internal operand registers, set gnt to onehot(winner), set last to the winner, and go to ADD.
REQ-018 In IDLE with req == 0, the block SHALL hold state and keep gnt at 0.
REQ-019 In ADD, on the next edge, the block SHALL clear gnt, load sum with opA+opB truncated to DATAWIDTH (two's-complement wrap), load ovf, set id to last, set valid to 1, and go to DONE.
REQ-020 ovf SHALL be 1 exactly when opA and opB have equal sign bits and sum's sign bit differs from them.
REQ-021 In DONE, valid, sum, ovf and id SHALL hold stable until an edge with ack=1.
REQ-022 On that ack edge the block SHALL clear valid and go to IDLE; sum, ovf and id SHALL keep their last values.
REQ-023 ack SHALL be ignored in IDLE and ADD.
REQ-024 gnt SHALL be high for exactly one cycle per operation, one cycle before valid rises.
REQ-025 A requester SHALL hold req and its operands until it sees its gnt bit; changes to its operands after capture SHALL not affect the result.
REQ-026 req still high after gnt SHALL be treated as a new request, arbitrated normally at the next IDLE edge.
REQ-027 Latency SHALL be: req sampled at edge k -> gnt high after edge k -> valid high after edge k+1.
REQ-028 The minimum issue interval SHALL be 3 cycles; the next grant is possible at the edge after the ack edge.
REQ-029 With all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0,...
REQ-030 A single continuously-requesting requester SHALL be granted on every issue opportunity.

Reset
REQ-031 When Rst=0, the block SHALL asynchronously force state=IDLE, gnt=0, valid=0, sum=0, ovf=0, id=0, opA=opB=0 and last=3, so that requester 0 has top priority first.
REQ-032 Reset asserted in ADD or DONE SHALL discard the in-flight result with no valid pulse, and SHALL not require ack.
REQ-033 After Rst deasserts, the first edge SHALL follow REQ-016 and REQ-018.

Verification
REQ-034 Single request: after reset, req=0001, a0=5, b0=3 -> gnt=0001 for one cycle, then valid=1, sum=8, id=0, ovf=0; ack -> valid=0.
REQ-035 Overflow: a2=100, b2=50, only req[2] set -> sum=-106, ovf=1, id=2; a2=-100, b2=-50 -> sum=106, ovf=1.
REQ-036 Fairness: req=1111 held, ack tied high -> gnt sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
REQ-037 Backpressure: ack=0 for 10 cycles in DONE -> valid, sum and id stable throughout, no new gnt; ack=1 -> next grant at the following edge.
REQ-038 Reset mid-op: Rst=0 in ADD -> all outputs 0 immediately and no valid pulse; after release, req=1000 and req=0001 together -> gnt=0001 first.
